// File: rtl/parking_pkg.sv
// Shared definitions for the parking session tracker and its fee calculator.
// Holds the common data widths, the tracker FSM state type, the session slot
// record and a helper that sizes slot-index fields.
package parking_pkg;

  localparam int TIME_W = 32;
  localparam int ID_W   = 8;
  localparam int FEE_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [TIME_W-1:0] t_entry;
  } slot_t;

  // Width of a slot index; a single-slot table still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/parking_session_tracker_table.sv
// Session slot table.
// Stores {valid, id, t_entry} per slot, performs a combinational id lookup
// over the valid slots, writes new sessions into the lowest free slot and
// invalidates a slot by index.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   lookup_id             id to search for
//   hit, hit_idx, hit_t   lookup result: found, slot index, stored entry time
//   wr_en, wr_id, wr_time store a new session in the lowest free slot
//   inv_en, inv_idx       invalidate the given slot
//   full, occupied_count  table occupancy
module parking_session_tracker_table
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int IDX_W     = idx_w(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ID_W-1:0]   lookup_id,
  output logic              hit,
  output logic [IDX_W-1:0]  hit_idx,
  output logic [TIME_W-1:0] hit_t,
  input  logic              wr_en,
  input  logic [ID_W-1:0]   wr_id,
  input  logic [TIME_W-1:0] wr_time,
  input  logic              inv_en,
  input  logic [IDX_W-1:0]  inv_idx,
  output logic              full,
  output logic [4:0]        occupied_count
);

  slot_t slots_q [NUM_SLOTS];

  logic [IDX_W-1:0] free_idx;

  // Lookup, lowest-free encoder and population count over all slots.
  // Scanning from the top down lets the lowest matching index win.
  always_comb begin
    hit            = 1'b0;
    hit_idx        = '0;
    hit_t          = '0;
    free_idx       = '0;
    occupied_count = 5'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      hit      = (slots_q[i].valid && (slots_q[i].id == lookup_id)) ? 1'b1 : hit;
      hit_idx  = (slots_q[i].valid && (slots_q[i].id == lookup_id)) ? IDX_W'(i) : hit_idx;
      hit_t    = (slots_q[i].valid && (slots_q[i].id == lookup_id)) ? slots_q[i].t_entry : hit_t;
      free_idx = (!slots_q[i].valid) ? IDX_W'(i) : free_idx;
      occupied_count = occupied_count + {4'd0, slots_q[i].valid};
    end
  end

  assign full = (occupied_count == 5'(NUM_SLOTS));

  // Slot storage: a write lands only in the lowest free slot and never when full.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (wr_en && !full && (free_idx == IDX_W'(i))) begin
          slots_q[i] <= '{valid: 1'b1, id: wr_id, t_entry: wr_time};
        end else if (inv_en && (inv_idx == IDX_W'(i))) begin
          slots_q[i].valid <= 1'b0;
        end else begin
          slots_q[i] <= slots_q[i];
        end
      end
    end
  end

endmodule

// File: rtl/parking_session_tracker.sv
// Parking session tracker: initiator side of the fee-calculation interface.
// Timestamps vehicle entries into the slot table; on an exit it looks up the
// entry time, issues a one-cycle calculate_fee request, waits for a rising
// edge of fee_valid (or a timeout) and emits a one-cycle bill record.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   vehicle_entry/entry_id             entry event
//   vehicle_exit/exit_id               exit event
//   ready, entry_ack, entry_reject,
//   exit_drop                          status and event responses
//   entry_time, exit_time, vehicle_id,
//   calculate_fee                      request to the fee calculator
//   fee_amount, fee_valid              response from the fee calculator
//   bill_valid, bill_id, bill_amount,
//   bill_error                         bill record
//   occupied_count, full, time_now     table occupancy and timestamp
module parking_session_tracker
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS   = 8,
  parameter int TICK_DIV    = 1,
  parameter int FEE_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vehicle_entry,
  input  logic [ID_W-1:0]   entry_id,
  input  logic              vehicle_exit,
  input  logic [ID_W-1:0]   exit_id,
  output logic              ready,
  output logic              entry_ack,
  output logic              entry_reject,
  output logic              exit_drop,
  output logic [TIME_W-1:0] entry_time,
  output logic [TIME_W-1:0] exit_time,
  output logic [ID_W-1:0]   vehicle_id,
  output logic              calculate_fee,
  input  logic [FEE_W-1:0]  fee_amount,
  input  logic              fee_valid,
  output logic              bill_valid,
  output logic [ID_W-1:0]   bill_id,
  output logic [FEE_W-1:0]  bill_amount,
  output logic              bill_error,
  output logic [4:0]        occupied_count,
  output logic              full,
  output logic [TIME_W-1:0] time_now
);

  localparam int IDX_W = idx_w(NUM_SLOTS);

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       cnt_q;
  logic [31:0]       div_q;
  logic [TIME_W-1:0] time_q;
  logic              fee_valid_prev_q;
  logic              ready_q, entry_ack_q, entry_reject_q, exit_drop_q;
  logic              calculate_fee_q, bill_valid_q, bill_error_q;
  logic [TIME_W-1:0] entry_time_q, exit_time_q;
  logic [ID_W-1:0]   vehicle_id_q, bill_id_q;
  logic [FEE_W-1:0]  bill_amount_q;

  logic              tbl_hit, tbl_full;
  logic [IDX_W-1:0]  tbl_idx;
  logic [TIME_W-1:0] tbl_t;
  logic              entry_ok_d, wr_en_d, inv_en_d, fee_rise_d;

  // The exit wins a simultaneous entry, so the single lookup port follows it.
  assign entry_ok_d = !tbl_hit && !tbl_full;
  assign wr_en_d    = (state_q == ST_IDLE) && vehicle_entry && !vehicle_exit && entry_ok_d;
  // A level left high by an earlier transaction must not be accepted again.
  assign fee_rise_d = fee_valid && !fee_valid_prev_q;
  assign inv_en_d   = (state_q == ST_WAIT) && fee_rise_d;

  parking_session_tracker_table #(
    .NUM_SLOTS (NUM_SLOTS),
    .IDX_W     (IDX_W)
  ) u_table (
    .clk            (clk),
    .reset          (reset),
    .lookup_id      (vehicle_exit ? exit_id : entry_id),
    .hit            (tbl_hit),
    .hit_idx        (tbl_idx),
    .hit_t          (tbl_t),
    .wr_en          (wr_en_d),
    .wr_id          (entry_id),
    .wr_time        (time_q),
    .inv_en         (inv_en_d),
    .inv_idx        (idx_q),
    .full           (tbl_full),
    .occupied_count (occupied_count)
  );

  // Free-running timestamp, advanced once every TICK_DIV cycles in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= 32'd0;
      time_q <= '0;
    end else if (div_q == 32'(TICK_DIV - 1)) begin
      div_q  <= 32'd0;
      time_q <= time_q + 32'd1;
    end else begin
      div_q  <= div_q + 32'd1;
      time_q <= time_q;
    end
  end

  // Transaction FSM with all event and bill outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      idx_q            <= '0;
      cnt_q            <= 32'd0;
      fee_valid_prev_q <= 1'b0;
      ready_q          <= 1'b1;
      entry_ack_q      <= 1'b0;
      entry_reject_q   <= 1'b0;
      exit_drop_q      <= 1'b0;
      calculate_fee_q  <= 1'b0;
      bill_valid_q     <= 1'b0;
      bill_error_q     <= 1'b0;
      entry_time_q     <= '0;
      exit_time_q      <= '0;
      vehicle_id_q     <= '0;
      bill_id_q        <= '0;
      bill_amount_q    <= '0;
    end else begin
      fee_valid_prev_q <= fee_valid;
      entry_ack_q      <= 1'b0;
      calculate_fee_q  <= 1'b0;
      bill_valid_q     <= 1'b0;
      // Outside IDLE every event is refused; in IDLE the case below refines this.
      entry_reject_q   <= vehicle_entry;
      exit_drop_q      <= vehicle_exit;
      case (state_q)
        ST_IDLE: begin
          exit_drop_q <= 1'b0;
          if (vehicle_exit) begin
            ready_q       <= 1'b0;
            bill_id_q     <= exit_id;
            bill_amount_q <= '0;
            if (tbl_hit) begin
              idx_q        <= tbl_idx;
              entry_time_q <= tbl_t;
              exit_time_q  <= time_q;
              vehicle_id_q <= exit_id;
              bill_error_q <= 1'b0;
              state_q      <= ST_REQ;
            end else begin
              bill_error_q <= 1'b1;
              state_q      <= ST_DONE;
            end
          end else begin
            entry_ack_q    <= vehicle_entry && entry_ok_d;
            entry_reject_q <= vehicle_entry && !entry_ok_d;
          end
        end
        ST_REQ: begin
          calculate_fee_q <= 1'b1;
          cnt_q           <= 32'd0;
          state_q         <= ST_WAIT;
        end
        ST_WAIT: begin
          if (fee_rise_d) begin
            bill_amount_q <= fee_amount;
            bill_error_q  <= 1'b0;
            state_q       <= ST_DONE;
          end else if (cnt_q == 32'(FEE_TIMEOUT - 1)) begin
            bill_amount_q <= '0;
            bill_error_q  <= 1'b1;
            state_q       <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_DONE: begin
          bill_valid_q <= 1'b1;
          ready_q      <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready         = ready_q;
  assign entry_ack     = entry_ack_q;
  assign entry_reject  = entry_reject_q;
  assign exit_drop     = exit_drop_q;
  assign entry_time    = entry_time_q;
  assign exit_time     = exit_time_q;
  assign vehicle_id    = vehicle_id_q;
  assign calculate_fee = calculate_fee_q;
  assign bill_valid    = bill_valid_q;
  assign bill_id       = bill_id_q;
  assign bill_amount   = bill_amount_q;
  assign bill_error    = bill_error_q;
  assign full          = tbl_full;
  assign time_now      = time_q;

endmodule
